// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU data-memory responder: the default address
// prefix of the memory-mapped I/O block, the byte offsets of the I/O
// registers, the timer control bit positions and the timer state encoding.
// ---------------------------------------------------------------------------
package cpu_pkg;

    // address[31:8] value that selects the 256-byte I/O block
    localparam logic [23:0] IO_PREFIX_DEFAULT = 24'hFFFFFF;

    // I/O register byte offsets within the block
    localparam logic [7:0] MMIO_LED    = 8'h00;
    localparam logic [7:0] MMIO_SEG    = 8'h04;
    localparam logic [7:0] MMIO_CYCLE  = 8'h08;
    localparam logic [7:0] MMIO_TLOAD  = 8'h0C;
    localparam logic [7:0] MMIO_TCTRL  = 8'h10;
    localparam logic [7:0] MMIO_TSTAT  = 8'h14;
    localparam logic [7:0] MMIO_TCOUNT = 8'h18;

    // TCTRL bit positions
    localparam int TCTRL_EN   = 0;
    localparam int TCTRL_AUTO = 1;

    // Countdown timer states
    typedef enum logic {
        TMR_IDLE = 1'b0,
        TMR_RUN  = 1'b1
    } tmr_state_t;

endpackage

// File: rtl/mmio_timer.sv
// ---------------------------------------------------------------------------
// mmio_timer
// Countdown timer behind the TLOAD / TCTRL / TSTAT / TCOUNT registers.
// The parent decodes the bus and hands in one write strobe per register plus
// the shared write data; this block returns the register contents.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   tload_wr   write strobe for TLOAD
//   tctrl_wr   write strobe for TCTRL
//   tstat_wr   write strobe for TSTAT (bit0 is write-one-to-clear)
//   wdata      write data shared by all strobes
//   tload      current reload value
//   tctrl      current control bits {AUTO, EN}
//   exp        expired flag
//   count      current countdown value
// ---------------------------------------------------------------------------
module mmio_timer
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        tload_wr,
    input  logic        tctrl_wr,
    input  logic        tstat_wr,
    input  logic [31:0] wdata,
    output logic [31:0] tload,
    output logic [1:0]  tctrl,
    output logic        exp,
    output logic [31:0] count
);

    tmr_state_t state;

    logic expiring;
    assign expiring = (state == TMR_RUN) && (count == 32'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= TMR_IDLE;
            count <= 32'd0;
            tload <= 32'd0;
            tctrl <= 2'b00;
            exp   <= 1'b0;
        end else begin
            // TLOAD only feeds later reloads; an active countdown keeps going
            if (tload_wr) begin
                tload <= wdata;
            end

            // An expiry in the same cycle as a clear wins, so no event is lost
            if (expiring) begin
                exp <= 1'b1;
            end else if (tstat_wr && wdata[0]) begin
                exp <= 1'b0;
            end

            // A TCTRL write overrides the normal countdown: EN=1 (re)starts
            // from TLOAD, EN=0 parks the count where it is
            if (tctrl_wr) begin
                tctrl <= wdata[1:0];
                if (wdata[TCTRL_EN]) begin
                    count <= tload;
                    state <= TMR_RUN;
                end else begin
                    state <= TMR_IDLE;
                end
            end else if (state == TMR_RUN) begin
                if (count == 32'd0) begin
                    if (tctrl[TCTRL_AUTO]) begin
                        count <= tload;
                    end else begin
                        tctrl[TCTRL_EN] <= 1'b0;
                        state           <= TMR_IDLE;
                    end
                end else begin
                    count <= count - 32'd1;
                end
            end
        end
    end

endmodule

// File: rtl/mmio_responder.sv
// ---------------------------------------------------------------------------
// mmio_responder
// Data-memory responder for the CPU: word-addressed RAM in the low region
// and a block of memory-mapped I/O registers (LEDs, 7-segment, cycle counter,
// countdown timer) in the 256 bytes selected by IO_PREFIX.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   address    byte address; bits [1:0] are ignored
//   data       write data
//   wren       write enable, one word per cycle
//   q          registered read data (one cycle latency)
//   LEDR       LED register
//   SEG        7-segment register
//   irq        timer expired flag
// ---------------------------------------------------------------------------
module mmio_responder
    import cpu_pkg::*;
#(
    parameter int          RAM_WORDS = 256,
    parameter logic [23:0] IO_PREFIX = IO_PREFIX_DEFAULT
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q,
    output logic [9:0]  LEDR,
    output logic [7:0]  SEG,
    output logic        irq
);

    localparam int AW = $clog2(RAM_WORDS);

    logic [31:0] mem [RAM_WORDS];
    logic [31:0] cycle;
    logic [31:0] rd_data;
    logic [31:0] tload;
    logic [31:0] tcount;
    logic [1:0]  tctrl;
    logic        exp;

    // Byte-lane bits play no part in decode; word aligned offset only
    logic        is_io;
    logic [7:0]  offset;
    logic [AW-1:0] ram_idx;
    logic [1:0]  unused_lane;

    assign is_io       = (address[31:8] == IO_PREFIX);
    assign offset      = {address[7:2], 2'b00};
    assign ram_idx     = address[AW+1:2];
    assign unused_lane = address[1:0];

    logic io_wr;
    assign io_wr = wren && is_io;

    mmio_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .tload_wr (io_wr && (offset == MMIO_TLOAD)),
        .tctrl_wr (io_wr && (offset == MMIO_TCTRL)),
        .tstat_wr (io_wr && (offset == MMIO_TSTAT)),
        .wdata    (data),
        .tload    (tload),
        .tctrl    (tctrl),
        .exp      (exp),
        .count    (tcount)
    );

    assign irq = exp;

    // RAM is never cleared; a write during reset is dropped
    always_ff @(posedge clk) begin
        if (!rst && wren && !is_io) begin
            mem[ram_idx] <= data;
        end
    end

    // Read mux sees pre-edge state, giving old data on read-during-write
    always_comb begin
        rd_data = 32'd0;
        if (is_io) begin
            case (offset)
                MMIO_LED:    rd_data = {22'd0, LEDR};
                MMIO_SEG:    rd_data = {24'd0, SEG};
                MMIO_CYCLE:  rd_data = cycle;
                MMIO_TLOAD:  rd_data = tload;
                MMIO_TCTRL:  rd_data = {30'd0, tctrl};
                MMIO_TSTAT:  rd_data = {31'd0, exp};
                MMIO_TCOUNT: rd_data = tcount;
                default:     rd_data = 32'd0;
            endcase
        end else begin
            rd_data = mem[ram_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= 32'd0;
            LEDR  <= 10'd0;
            SEG   <= 8'd0;
            cycle <= 32'd0;
        end else begin
            q     <= rd_data;
            cycle <= cycle + 32'd1;
            if (io_wr && (offset == MMIO_LED)) begin
                LEDR <= data[9:0];
            end
            if (io_wr && (offset == MMIO_SEG)) begin
                SEG <= data[7:0];
            end
        end
    end

endmodule

// File: tb/tb_mmio_responder.sv
// ---------------------------------------------------------------------------
// tb_mmio_responder
// Directed self-checking bench for mmio_responder. Inputs change 1 time unit
// after each rising edge and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_mmio_responder;

    localparam logic [31:0] A_LED    = 32'hFFFFFF00;
    localparam logic [31:0] A_SEG    = 32'hFFFFFF04;
    localparam logic [31:0] A_CYCLE  = 32'hFFFFFF08;
    localparam logic [31:0] A_TLOAD  = 32'hFFFFFF0C;
    localparam logic [31:0] A_TCTRL  = 32'hFFFFFF10;
    localparam logic [31:0] A_TSTAT  = 32'hFFFFFF14;
    localparam logic [31:0] A_TCOUNT = 32'hFFFFFF18;
    localparam logic [31:0] A_HOLE   = 32'hFFFFFF20;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q;
    logic [9:0]  LEDR;
    logic [7:0]  SEG;
    logic        irq;

    int compared   = 0;
    int mismatched = 0;

    mmio_responder #(.RAM_WORDS(256), .IO_PREFIX(24'hFFFFFF)) dut (
        .clk     (clk),
        .rst     (rst),
        .address (address),
        .data    (data),
        .wren    (wren),
        .q       (q),
        .LEDR    (LEDR),
        .SEG     (SEG),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        address = a;
        data    = d;
        wren    = 1'b1;
        step();
        wren    = 1'b0;
        address = A_HOLE;
    endtask

    task automatic do_read(input logic [31:0] a);
        address = a;
        wren    = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        compared++;
        if (q !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_q: got %h want %h", q, 32'd0); end
        compared++;
        if (LEDR !== 10'd0) begin mismatched++; $display("[TB] FAIL reset_ledr: got %h want %h", LEDR, 10'd0); end
        compared++;
        if (SEG !== 8'd0) begin mismatched++; $display("[TB] FAIL reset_seg: got %h want %h", SEG, 8'd0); end
        compared++;
        if (irq !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_irq: got %b want %b", irq, 1'b0); end
        // cycle counter is 0 at the first edge after reset is released
        rst = 1'b0;
        do_read(A_CYCLE);
        compared++;
        if (q !== 32'd0) begin mismatched++; $display("[TB] FAIL cycle_first: got %h want %h", q, 32'd0); end
        do_read(A_CYCLE);
        compared++;
        if (q !== 32'd1) begin mismatched++; $display("[TB] FAIL cycle_second: got %h want %h", q, 32'd1); end
    endtask

    task automatic test_ram();
        do_write(32'h40, 32'h12345678);
        do_read(32'h40);
        compared++;
        if (q !== 32'h12345678) begin mismatched++; $display("[TB] FAIL ram_read: got %h want %h", q, 32'h12345678); end
        do_read(32'h440);
        compared++;
        if (q !== 32'h12345678) begin mismatched++; $display("[TB] FAIL ram_alias: got %h want %h", q, 32'h12345678); end
        // read-during-write returns the old word
        do_write(32'h44, 32'hAAAA5555);
        do_write(32'h44, 32'hDEADBEEF);
        compared++;
        if (q !== 32'hAAAA5555) begin mismatched++; $display("[TB] FAIL ram_rdw_old: got %h want %h", q, 32'hAAAA5555); end
        do_read(32'h44);
        compared++;
        if (q !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL ram_rdw_new: got %h want %h", q, 32'hDEADBEEF); end
    endtask

    task automatic test_io_regs();
        do_write(A_LED, 32'h000003FF);
        compared++;
        if (LEDR !== 10'h3FF) begin mismatched++; $display("[TB] FAIL led_out: got %h want %h", LEDR, 10'h3FF); end
        do_write(A_SEG, 32'h000000A5);
        compared++;
        if (SEG !== 8'hA5) begin mismatched++; $display("[TB] FAIL seg_out: got %h want %h", SEG, 8'hA5); end
        do_read(A_LED);
        compared++;
        if (q !== 32'h000003FF) begin mismatched++; $display("[TB] FAIL led_read: got %h want %h", q, 32'h000003FF); end
        do_read(A_SEG);
        compared++;
        if (q !== 32'h000000A5) begin mismatched++; $display("[TB] FAIL seg_read: got %h want %h", q, 32'h000000A5); end
        do_write(A_HOLE, 32'hFFFFFFFF);
        do_read(A_HOLE);
        compared++;
        if (q !== 32'd0) begin mismatched++; $display("[TB] FAIL hole_read: got %h want %h", q, 32'd0); end
    endtask

    task automatic test_cycle();
        logic [31:0] c1;
        logic [31:0] c2;
        do_read(A_CYCLE);
        c1 = q;
        do_write(A_CYCLE, 32'h00000000);
        step();
        step();
        step();
        do_read(A_CYCLE);
        c2 = q;
        compared++;
        if (c2 - c1 !== 32'd5) begin mismatched++; $display("[TB] FAIL cycle_delta: got %0d want %0d", c2 - c1, 5); end
    endtask

    task automatic test_timer_oneshot();
        do_write(A_TLOAD, 32'd3);
        do_write(A_TCTRL, 32'd1);
        do_read(A_TCOUNT);
        compared++;
        if (q !== 32'd3) begin mismatched++; $display("[TB] FAIL os_count3: got %h want %h", q, 32'd3); end
        do_read(A_TCOUNT);
        compared++;
        if (q !== 32'd2) begin mismatched++; $display("[TB] FAIL os_count2: got %h want %h", q, 32'd2); end
        do_read(A_TCOUNT);
        compared++;
        if (q !== 32'd1) begin mismatched++; $display("[TB] FAIL os_count1: got %h want %h", q, 32'd1); end
        compared++;
        if (irq !== 1'b0) begin mismatched++; $display("[TB] FAIL os_irq_early: got %b want %b", irq, 1'b0); end
        do_read(A_TCOUNT);
        compared++;
        if (q !== 32'd0) begin mismatched++; $display("[TB] FAIL os_count0: got %h want %h", q, 32'd0); end
        compared++;
        if (irq !== 1'b1) begin mismatched++; $display("[TB] FAIL os_irq_set: got %b want %b", irq, 1'b1); end
        do_read(A_TCTRL);
        compared++;
        if (q !== 32'd0) begin mismatched++; $display("[TB] FAIL os_en_cleared: got %h want %h", q, 32'd0); end
        do_read(A_TCOUNT);
        compared++;
        if (q !== 32'd0) begin mismatched++; $display("[TB] FAIL os_count_hold: got %h want %h", q, 32'd0); end
        do_write(A_TSTAT, 32'd0);
        compared++;
        if (irq !== 1'b1) begin mismatched++; $display("[TB] FAIL os_w0_noeffect: got %b want %b", irq, 1'b1); end
        do_read(A_TSTAT);
        compared++;
        if (q !== 32'd1) begin mismatched++; $display("[TB] FAIL os_tstat_read: got %h want %h", q, 32'd1); end
        do_write(A_TSTAT, 32'd1);
        compared++;
        if (irq !== 1'b0) begin mismatched++; $display("[TB] FAIL os_w1c: got %b want %b", irq, 1'b0); end
    endtask

    task automatic test_timer_zero();
        do_write(A_TLOAD, 32'd0);
        do_write(A_TCTRL, 32'd1);
        compared++;
        if (irq !== 1'b0) begin mismatched++; $display("[TB] FAIL zero_irq_early: got %b want %b", irq, 1'b0); end
        step();
        compared++;
        if (irq !== 1'b1) begin mismatched++; $display("[TB] FAIL zero_irq_set: got %b want %b", irq, 1'b1); end
        do_write(A_TSTAT, 32'd1);
        compared++;
        if (irq !== 1'b0) begin mismatched++; $display("[TB] FAIL zero_clear: got %b want %b", irq, 1'b0); end
    endtask

    task automatic test_timer_auto();
        do_write(A_TLOAD, 32'd1);
        do_write(A_TCTRL, 32'd3);
        do_read(A_TCOUNT);
        compared++;
        if (q !== 32'd1 || irq !== 1'b0) begin mismatched++; $display("[TB] FAIL auto_e1: got q=%h irq=%b want q=%h irq=%b", q, irq, 32'd1, 1'b0); end
        do_read(A_TCOUNT);
        compared++;
        if (q !== 32'd0 || irq !== 1'b1) begin mismatched++; $display("[TB] FAIL auto_e2: got q=%h irq=%b want q=%h irq=%b", q, irq, 32'd0, 1'b1); end
        do_read(A_TCOUNT);
        compared++;
        if (q !== 32'd1) begin mismatched++; $display("[TB] FAIL auto_reload: got %h want %h", q, 32'd1); end
        // clear lands on an expiry edge: set wins
        do_write(A_TSTAT, 32'd1);
        compared++;
        if (irq !== 1'b1) begin mismatched++; $display("[TB] FAIL auto_set_wins: got %b want %b", irq, 1'b1); end
        do_write(A_TSTAT, 32'd1);
        compared++;
        if (irq !== 1'b0) begin mismatched++; $display("[TB] FAIL auto_w1c: got %b want %b", irq, 1'b0); end
        step();
        compared++;
        if (irq !== 1'b1) begin mismatched++; $display("[TB] FAIL auto_reexpire: got %b want %b", irq, 1'b1); end
        // stopping freezes the count (reloaded to 1) and leaves EXP alone
        do_write(A_TCTRL, 32'd0);
        do_read(A_TCOUNT);
        do_read(A_TCOUNT);
        compared++;
        if (q !== 32'd1 || irq !== 1'b1) begin mismatched++; $display("[TB] FAIL auto_frozen: got q=%h irq=%b want q=%h irq=%b", q, irq, 32'd1, 1'b1); end
    endtask

    task automatic test_reset_mid();
        do_write(A_TLOAD, 32'd100);
        do_write(A_TCTRL, 32'd1);
        step();
        step();
        address = A_LED;
        data    = 32'h155;
        wren    = 1'b1;
        rst     = 1'b1;
        step();
        wren    = 1'b0;
        rst     = 1'b0;
        compared++;
        if (q !== 32'd0 || LEDR !== 10'd0 || SEG !== 8'd0 || irq !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rst_outputs: got q=%h led=%h seg=%h irq=%b want all zero", q, LEDR, SEG, irq);
        end
        do_read(A_TCOUNT);
        compared++;
        if (q !== 32'd0) begin mismatched++; $display("[TB] FAIL rst_tcount: got %h want %h", q, 32'd0); end
        do_read(A_TLOAD);
        compared++;
        if (q !== 32'd0) begin mismatched++; $display("[TB] FAIL rst_tload: got %h want %h", q, 32'd0); end
        step();
        do_read(A_TCOUNT);
        compared++;
        if (q !== 32'd0) begin mismatched++; $display("[TB] FAIL rst_idle: got %h want %h", q, 32'd0); end
        do_read(32'h40);
        compared++;
        if (q !== 32'h12345678) begin mismatched++; $display("[TB] FAIL rst_ram_kept: got %h want %h", q, 32'h12345678); end
    endtask

    initial begin
        rst     = 1'b1;
        wren    = 1'b0;
        address = A_HOLE;
        data    = 32'd0;
        test_reset();
        test_ram();
        test_io_regs();
        test_cycle();
        test_timer_oneshot();
        test_timer_zero();
        test_timer_auto();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mmio_responder.md
# mmio_responder

Responder for the CPU's data-memory port. Accepts the CPU-issued address, write data and write enable; serves word-addressed RAM in the low region and a block of memory-mapped I/O registers in the top 256 bytes. The I/O block holds the LED and 7-segment output registers, a free-running cycle counter and a countdown timer. It replaces the bare data RAM in the CPU top level, so programs drive board I/O and time events with ordinary `lw`/`sw`.

## Interface
- `RAM_WORDS`, default 256: RAM depth in 32-bit words; power of two.
- `IO_PREFIX`, default 24'hFFFFFF: value of `address[31:8]` that selects the I/O region.
- `clk  input  1  system clock; all state updates on the rising edge`
- `rst  input  1  synchronous, active-high reset`
- `address  input  32  byte address from the ALU result; bits [1:0] ignored`
- `data  input  32  write data (Rt)`
- `wren  input  1  write enable, one word per cycle`
- `q  output  32  registered read data`
- `LEDR  output  10  LED register`
- `SEG  output  8  7-segment register`
- `irq  output  1  timer expired flag (level)`

## Operation
- Region decode: `address[31:8] == IO_PREFIX` selects I/O; otherwise RAM. RAM index is `address[log2(RAM_WORDS)+1:2]`, so higher bits alias (wrap-around).
- I/O register map, byte offset `address[7:0]`:
  - 0x00 LED: RW; bits [9:0]; reads zero-extended.
  - 0x04 SEG: RW; bits [7:0].
  - 0x08 CYCLE: RO; 32-bit free-running counter, +1 every cycle, wraps 0xFFFFFFFF→0.
  - 0x0C TLOAD: RW; 32-bit reload value.
  - 0x10 TCTRL: RW; bit0 EN, bit1 AUTO.
  - 0x14 TSTAT: bit0 EXP; read returns EXP; writing 1 to bit0 clears it (W1C); writing 0 has no effect.
  - 0x18 TCOUNT: RO; current countdown value.
  - Other offsets: read 0, writes ignored. Writes to RO registers are ignored.
- Timer FSM, states IDLE and RUN:
  - IDLE: count holds. A write to TCTRL with EN=1 loads count←TLOAD and enters RUN.
  - RUN: count decrements by 1 per cycle. When count==0: set EXP. If AUTO=1, reload count←TLOAD and stay in RUN. Otherwise clear EN and go to IDLE.
  - A write to TCTRL with EN=0 in RUN goes to IDLE. The count is frozen and EXP is untouched.
  - A write to TCTRL with EN=1 in RUN restarts the countdown from TLOAD.
  - A TLOAD write during RUN affects only the next reload.
  - TLOAD=0 with EN: EXP sets one cycle after entering RUN.
- `irq` = EXP.

## Timing
- Writes commit at the rising edge where `wren`=1.
- Reads: `q` is registered. The value after edge N reflects the address presented before edge N, with a latency of 1 cycle.
- Read-during-write to the same location returns the old data.
- CYCLE read returns the pre-increment value at the sampling edge.
- Same-cycle EXP set (expiry) and W1C clear: set wins, and EXP stays 1.
- Reset, including mid-countdown, sets the following to 0: `q`, `LEDR`, `SEG`, CYCLE, TLOAD, TCTRL, EXP and count. The FSM returns to IDLE. RAM contents are not reset.
- Reset has priority over any same-cycle write.

## Structure
- Shared package `cpu_pkg` holds:
  - `IO_PREFIX` default;
  - register offset constants (`MMIO_LED`, `MMIO_SEG`, `MMIO_CYCLE`, `MMIO_TLOAD`, `MMIO_TCTRL`, `MMIO_TSTAT`, `MMIO_TCOUNT`);
  - TCTRL bit indices;
  - the timer state enum (`TMR_IDLE`, `TMR_RUN`).
- Sub-module `mmio_timer` contains the FSM, count, TLOAD, TCTRL and EXP. Its interface is write strobes plus write data in, and register values out.
- `mmio_responder` holds the decode, RAM, LED/SEG/CYCLE registers and the `q` read mux.

## Test plan
- Write 0x12345678 to RAM 0x40, then read 0x40 → `q`=0x12345678 one cycle after the read address; a read of 0x40+4·RAM_WORDS returns the same value (alias).
- Write 0x3FF to 0xFFFFFF00 and 0xA5 to 0xFFFFFF04 → `LEDR`=0x3FF and `SEG`=0xA5 the next cycle; read 0xFFFFFF00 → 0x000003FF.
- TLOAD=3, then TCTRL=1 → TCOUNT reads 3,2,1,0; EXP/`irq` rises 4 cycles after the TCTRL write; the FSM returns to IDLE with TCTRL.EN=0.
- TLOAD=1, TCTRL=3 (auto) → `irq` sets and the count reloads to 1. A W1C of TSTAT timed on an expiry cycle leaves `irq`=1. A W1C on a non-expiry cycle clears it.
- Two CYCLE reads N cycles apart differ by N. Asserting `rst` mid-countdown → all outputs 0 and TCOUNT=0 the next cycle, and the RAM word written earlier is still readable.
- Read 0xFFFFFF20 → 0. A write to 0xFFFFFF08 leaves CYCLE counting unchanged.
